serial_seq_tx: RTL and testbench

- Parallel-to-serial frame transmitter: drives the single-bit serial stream that our serial sequence-checker FSMs consume, one bit per clk.
- Accepts a word plus a bit-length over a valid/ready handshake, shifts the bits out with frame markers, then inserts a programmable idle gap.
- Sits in front of the sequence recognizer in both benches and datapaths, replacing ad-hoc testbench bit drivers.

---
 rtl/serial_seq_tx.sv | 180 ++++++++++++++++++
 tb/tb_serial_seq_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_seq_tx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_seq_tx
//  Purpose  : Parallel-to-serial frame transmitter. Accepts a word and a bit
//             length over a valid/ready handshake, shifts the low L bits out
//             one per clock with sof/eof markers, then inserts an idle gap of
//             GAP cycles before the next frame can be accepted.
//  Ports    : clk        - clock, rising edge
//             rst_n      - asynchronous active-low reset
//             in_valid   - frame request valid
//             in_ready   - frame can be accepted this cycle
//             in_data    - frame bits (low in_len bits used)
//             in_len     - frame length in bits (clamped to WIDTH)
//             abort      - synchronous cancel of the frame in progress
//             bit_out    - serial data bit (0 when bit_valid is low)
//             bit_valid  - bit_out carries a frame bit
//             sof / eof  - first / last bit of a frame
//             busy       - shifting or in the inter-frame gap
//             done       - one-cycle pulse after a frame completes normally
//  Revision : 1.0 - initial release
// ============================================================================
module serial_seq_tx #(
   parameter int WIDTH     = 8,
   parameter int LEN_W     = 4,
   parameter int GAP       = 1,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [LEN_W-1:0] in_len,
   input  logic             abort,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             sof,
   output logic             eof,
   output logic             busy,
   output logic             done
);

   localparam int               GAP_W       = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GAP_W-1:0] C_GAP_LOAD  = GAP_W'((GAP > 0) ? (GAP - 1) : 0);
   localparam logic             C_HAS_GAP   = (GAP > 0);
   localparam logic [LEN_W-1:0] C_WIDTH_LEN = LEN_W'(WIDTH);
   localparam logic [LEN_W-1:0] C_LEN_ONE   = LEN_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t             state_q,  state_d;
   logic [WIDTH-1:0]   shreg_q,  shreg_d;
   logic [LEN_W-1:0]   cnt_q,    cnt_d;
   logic [GAP_W-1:0]   gap_q,    gap_d;
   logic               first_q,  first_d;
   logic               done_q,   done_d;
   logic               rdy_q,    rdy_d;

   logic [LEN_W-1:0]   eff_len;
   logic [WIDTH-1:0]   load_val;
   logic [WIDTH-1:0]   shift_next;
   logic               cur_bit;
   logic               accept;

   // Lengths beyond WIDTH are clamped so the counter never exceeds the word.
   assign eff_len = (in_len > C_WIDTH_LEN) ? C_WIDTH_LEN : in_len;

   // The shift register always presents the next bit at a fixed end, so the
   // bit order is settled once at load time.
   generate
      if (MSB_FIRST != 0) begin : g_msb_first
         logic [LEN_W-1:0] shamt;
         // Left-align bit L-1 at the top so it leaves first; bits >= L fall off.
         assign shamt      = C_WIDTH_LEN - eff_len;
         assign load_val   = in_data << shamt;
         assign shift_next = shreg_q << 1;
         assign cur_bit    = shreg_q[WIDTH-1];
      end else begin : g_lsb_first
         // Bits >= L stay in the register but the counter stops before them.
         assign load_val   = in_data;
         assign shift_next = shreg_q >> 1;
         assign cur_bit    = shreg_q[0];
      end
   endgenerate

   // rdy_q keeps in_ready low during reset and for the release cycle.
   assign in_ready  = rdy_q & (state_q == ST_IDLE);
   assign accept    = in_valid & in_ready;
   assign bit_valid = (state_q == ST_SHIFT);
   assign bit_out   = bit_valid & cur_bit;
   assign sof       = bit_valid & first_q;
   assign eof       = bit_valid & (cnt_q == C_LEN_ONE);
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      first_d = 1'b0;
      done_d  = 1'b0;
      rdy_d   = 1'b1;
      case (state_q)
         ST_IDLE: begin
            // abort is deliberately ignored here, even on an accept cycle.
            if (accept) begin
               shreg_d = load_val;
               cnt_d   = eff_len;
               if (eff_len != '0) begin
                  state_d = ST_SHIFT;
                  first_d = 1'b1;
               end else begin
                  done_d = 1'b1;
                  if (C_HAS_GAP) begin
                     state_d = ST_GAP;
                     gap_d   = C_GAP_LOAD;
                  end
               end
            end
         end
         ST_SHIFT: begin
            if (abort) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               shreg_d = '0;
            end else begin
               shreg_d = shift_next;
               cnt_d   = cnt_q - C_LEN_ONE;
               if (cnt_q == C_LEN_ONE) begin
                  done_d = 1'b1;
                  if (C_HAS_GAP) begin
                     state_d = ST_GAP;
                     gap_d   = C_GAP_LOAD;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
         end
         ST_GAP: begin
            if (abort || (gap_q == '0)) begin
               state_d = ST_IDLE;
               gap_d   = '0;
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         gap_q   <= '0;
         first_q <= 1'b0;
         done_q  <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         first_q <= first_d;
         done_q  <= done_d;
         rdy_q   <= rdy_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_seq_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_seq_tx
//  Purpose  : Self-checking bench for serial_seq_tx. Four instances cover the
//             parameter corners: 0:GAP=1 MSB, 1:GAP=1 LSB, 2:GAP=0 MSB,
//             3:GAP=3 MSB. A timeline model predicts every output each cycle
//             and literal checks pin the recorded serial streams.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_seq_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] in_valid = '0;
   logic [3:0] abort_s  = '0;
   logic [7:0] in_data [4];
   logic [3:0] in_len  [4];
   logic [3:0] in_ready, bit_out, bit_valid, sof, eof, busy, done;

   int checks = 0;
   int errors = 0;

   serial_seq_tx #(.WIDTH(8), .LEN_W(4), .GAP(1), .MSB_FIRST(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_data(in_data[0]), .in_len(in_len[0]), .abort(abort_s[0]),
      .bit_out(bit_out[0]), .bit_valid(bit_valid[0]), .sof(sof[0]), .eof(eof[0]),
      .busy(busy[0]), .done(done[0]));
   serial_seq_tx #(.WIDTH(8), .LEN_W(4), .GAP(1), .MSB_FIRST(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_data(in_data[1]), .in_len(in_len[1]), .abort(abort_s[1]),
      .bit_out(bit_out[1]), .bit_valid(bit_valid[1]), .sof(sof[1]), .eof(eof[1]),
      .busy(busy[1]), .done(done[1]));
   serial_seq_tx #(.WIDTH(8), .LEN_W(4), .GAP(0), .MSB_FIRST(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_data(in_data[2]), .in_len(in_len[2]), .abort(abort_s[2]),
      .bit_out(bit_out[2]), .bit_valid(bit_valid[2]), .sof(sof[2]), .eof(eof[2]),
      .busy(busy[2]), .done(done[2]));
   serial_seq_tx #(.WIDTH(8), .LEN_W(4), .GAP(3), .MSB_FIRST(1)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
      .in_data(in_data[3]), .in_len(in_len[3]), .abort(abort_s[3]),
      .bit_out(bit_out[3]), .bit_valid(bit_valid[3]), .sof(sof[3]), .eof(eof[3]),
      .busy(busy[3]), .done(done[3]));

   function automatic int gap_of(int d);
      case (d)
         0, 1:    return 1;
         2:       return 0;
         default: return 3;
      endcase
   endfunction

   function automatic bit msb_of(int d);
      return (d != 1);
   endfunction

   // Vector layout: {in_ready, bit_valid, bit_out, sof, eof, busy, done}
   function automatic logic [6:0] act(int d);
      return {in_ready[d], bit_valid[d], bit_out[d], sof[d], eof[d], busy[d], done[d]};
   endfunction

   // ---------------- timeline model ----------------
   logic [6:0] sched [4][16];
   int         head [4];
   int         tail [4];
   bit         rel_pend = 1'b0;

   initial begin
      for (int d = 0; d < 4; d++) begin
         head[d] = 0; tail[d] = 0; in_data[d] = '0; in_len[d] = '0;
      end
   end

   always @(negedge clk) begin
      logic [6:0] exp_v, got;
      int L, g, idx;
      for (int d = 0; d < 4; d++) begin
         if (!rst_n || rel_pend)   exp_v = 7'b0000000;
         else if (head[d] < tail[d]) exp_v = sched[d][head[d]];
         else                      exp_v = 7'b1000000;
         got = act(d);
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL model dut%0d t=%0t: got %b expected %b (rdy,bv,bit,sof,eof,busy,done)",
                     d, $time, got, exp_v);
         end
         if (!rst_n) begin
            head[d] = 0; tail[d] = 0;
         end else if (!rel_pend) begin
            if (head[d] < tail[d]) head[d]++;
            if (abort_s[d] && exp_v[1]) begin
               head[d] = 0; tail[d] = 0;
            end else if (exp_v[6] && in_valid[d]) begin
               head[d] = 0; tail[d] = 0;
               L = (in_len[d] > 4'd8) ? 8 : int'(in_len[d]);
               g = gap_of(d);
               for (int k = 0; k < L; k++) begin
                  idx = msb_of(d) ? (L - 1 - k) : k;
                  sched[d][tail[d]] = {1'b0, 1'b1, in_data[d][idx], (k == 0), (k == L - 1), 1'b1, 1'b0};
                  tail[d]++;
               end
               if (g > 0) begin
                  for (int j = 0; j < g; j++) begin
                     sched[d][tail[d]] = {5'b00000, 1'b1, (j == 0)};
                     tail[d]++;
                  end
               end else begin
                  sched[d][tail[d]] = 7'b1000001;
                  tail[d]++;
               end
            end
         end
      end
      rel_pend = !rst_n;
   end

   // ---------------- stream recorder ----------------
   logic [15:0] rec_bits [4];
   int          rec_n    [4];
   int          done_cnt [4];
   int          spacing  [4];
   time         last_eof [4];

   initial begin
      for (int d = 0; d < 4; d++) begin
         rec_bits[d] = '0; rec_n[d] = 0; done_cnt[d] = 0; spacing[d] = 0; last_eof[d] = 0;
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < 4; d++) begin
         if (done[d]) done_cnt[d]++;
         if (bit_valid[d]) begin
            if (sof[d]) begin
               rec_bits[d] = '0;
               rec_n[d]    = 0;
               spacing[d]  = int'(($time - last_eof[d]) / 10);
            end
            rec_bits[d] = {rec_bits[d][14:0], bit_out[d]};
            rec_n[d]++;
            if (eof[d]) last_eof[d] = $time;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
      checks++;
      if (got !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp_v);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Holds the request until a posedge accepts it; returns 2 time units after
   // that posedge with in_valid dropped (a following send re-raises it at once).
   task automatic send(input int d, input logic [7:0] data, input logic [3:0] len);
      bit ok;
      ok = 1'b0;
      in_valid[d] = 1'b1; in_data[d] = data; in_len[d] = len;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready[d];
         @(posedge clk);
         #2;
      end
      if (!ok) begin
         errors++;
         $display("FAIL send_timeout dut%0d: in_ready never seen", d);
      end
      in_valid[d] = 1'b0;
   endtask

   initial begin
      cycles(3);
      check("reset_ready", {28'd0, in_ready}, 32'h0);
      check("reset_outs", {bit_valid, busy, done, sof}, 32'h0);
      rst_n = 1'b1;
      cycles(1);
      check("ready_after_release", {28'd0, in_ready}, 32'hF);

      // 8-bit MSB-first frame
      send(0, 8'hB4, 4'd8);
      cycles(12);
      check("b4_bits", {16'd0, rec_bits[0]} & 32'hFF, 32'hB4);
      check("b4_count", rec_n[0], 8);
      check("b4_done", done_cnt[0], 1);

      // LSB-first, 3 of 8 bits
      send(1, 8'hFD, 4'd3);
      cycles(8);
      check("fd_bits", {16'd0, rec_bits[1]}, 32'h5);
      check("fd_count", rec_n[1], 3);

      // 1-bit frame, zero-length frame, over-long length
      send(0, 8'h01, 4'd1);
      cycles(5);
      check("one_bit_count", rec_n[0], 1);
      check("one_bit_val", {16'd0, rec_bits[0]}, 32'h1);
      send(0, 8'hFF, 4'd0);
      cycles(5);
      check("zero_len_done", done_cnt[0], 3);
      check("zero_len_nobits", rec_n[0], 1);
      send(0, 8'hA5, 4'd12);
      cycles(12);
      check("len12_count", rec_n[0], 8);
      check("len12_bits", {16'd0, rec_bits[0]} & 32'hFF, 32'hA5);

      // back-to-back frames
      send(2, 8'hC3, 4'd8);
      send(2, 8'h5A, 4'd8);
      cycles(12);
      check("gap0_spacing", spacing[2], 2);
      check("gap0_second", {16'd0, rec_bits[2]} & 32'hFF, 32'h5A);
      send(3, 8'h0F, 4'd8);
      send(3, 8'h96, 4'd8);
      cycles(14);
      check("gap3_spacing", spacing[3], 5);
      check("gap3_second", {16'd0, rec_bits[3]} & 32'hFF, 32'h96);

      // abort on the 4th bit
      send(0, 8'hFF, 4'd8);
      cycles(3);
      abort_s[0] = 1'b1;
      cycles(1);
      abort_s[0] = 1'b0;
      @(negedge clk);
      check("abort4_state", {29'd0, bit_valid[0], busy[0], in_ready[0]}, 32'h1);
      cycles(3);
      check("abort4_nodone", done_cnt[0], 4);

      // abort on the eof cycle
      send(0, 8'hFF, 4'd8);
      cycles(7);
      check("abort_eof_at_eof", {31'd0, eof[0]}, 32'h1);
      abort_s[0] = 1'b1;
      cycles(1);
      abort_s[0] = 1'b0;
      cycles(3);
      check("abort_eof_nodone", done_cnt[0], 4);

      // abort in IDLE during acceptance is ignored
      abort_s[0] = 1'b1;
      send(0, 8'h3C, 4'd8);
      abort_s[0] = 1'b0;
      cycles(12);
      check("idle_abort_count", rec_n[0], 8);
      check("idle_abort_bits", {16'd0, rec_bits[0]} & 32'hFF, 32'h3C);

      // asynchronous reset mid-frame
      send(0, 8'h96, 4'd8);
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_outs", {in_ready, bit_out, bit_valid, sof, eof, busy, done}, 32'h0);
      cycles(1);
      rst_n = 1'b1;
      send(0, 8'h69, 4'd8);
      cycles(12);
      check("post_rst_count", rec_n[0], 8);
      check("post_rst_bits", {16'd0, rec_bits[0]} & 32'hFF, 32'h69);

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
